ili9341_spi_receiver: RTL and testbench

Display-side SPI decoder for the ILI9341 4-wire serial link (SCK, MOSI, CS, DC), used as a behavioural stand-in for the panel in simulation and as an on-FPGA loopback monitor. It deserialises command and data bytes and tracks the CASET/PASET address window. It assembles RAMWR data into RGB565 pixels, tagged with the (x, y) coordinate the panel would write. Output feeds a scoreboard or frame-buffer writer.

---
 rtl/ili9341_pkg.sv | 24 ++
 rtl/spi_byte_deserializer.sv | 69 ++++++
 rtl/ili9341_spi_receiver.sv | 156 +++++++++++++++
 tb/tb_ili9341_spi_receiver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// rtl/ili9341_pkg.sv - shared opcodes, decoder states and RGB565 colours for the ILI9341 link
package ili9341_pkg;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CASET = 3'd1;
  localparam state_t ST_PASET = 3'd2;
  localparam state_t ST_RAMWR = 3'd3;
  localparam state_t ST_SKIP  = 3'd4;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;
  localparam logic [15:0] RGB565_CYAN  = 16'h07FF;

endpackage

// File: rtl/spi_byte_deserializer.sv
// rtl/spi_byte_deserializer.sv - samples the 4-wire SPI pins and emits whole bytes with their DC flag
module spi_byte_deserializer (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs,
  input  logic       dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic       sck_q, sck_qq, mosi_q, cs_q, cs_qq, dc_q;
  logic       rise_q, cs_rise_q, mosi_d, dc_d;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;

  // Edge detect is registered along with the data/dc it qualifies, so they stay aligned.
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      sck_q     <= 1'b0;
      sck_qq    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      cs_qq     <= 1'b1;
      dc_q      <= 1'b0;
      rise_q    <= 1'b0;
      cs_rise_q <= 1'b0;
      mosi_d    <= 1'b0;
      dc_d      <= 1'b0;
    end else begin
      sck_q     <= sck;
      mosi_q    <= mosi;
      cs_q      <= cs;
      dc_q      <= dc;
      sck_qq    <= sck_q;
      cs_qq     <= cs_q;
      rise_q    <= sck_q & ~sck_qq & ~cs_q;
      cs_rise_q <= cs_q & ~cs_qq;
      mosi_d    <= mosi_q;
      dc_d      <= dc_q;
    end
  end

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_rise_q) begin
        bit_cnt <= 3'd0;
      end else if (rise_q) begin
        shreg   <= {shreg[5:0], mosi_d};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shreg, mosi_d};
          byte_dc    <= dc_d;
        end
      end
    end
  end

endmodule

// File: rtl/ili9341_spi_receiver.sv
// rtl/ili9341_spi_receiver.sv - ILI9341 command decoder tracking the address window and emitting RGB565 pixels
module ili9341_spi_receiver
  import ili9341_pkg::*;
#(
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 240,
  parameter int PIXEL_SIZE = 16,
  parameter int XW         = $clog2(WIDTH),
  parameter int YW         = $clog2(HEIGHT)
) (
  input  logic                  clk_out,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic                  spi_cs,
  input  logic                  spi_dc,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_byte,
  output logic                  pixel_valid,
  output logic [PIXEL_SIZE-1:0] pixel_data,
  output logic [XW-1:0]         pixel_x,
  output logic [YW-1:0]         pixel_y,
  output logic                  frame_done
);

  logic        byte_valid, byte_dc;
  logic [7:0]  byte_data;

  state_t      state;
  logic [1:0]  param_idx;
  logic [7:0]  param_hi;
  logic [15:0] param_start;
  logic        half;
  logic [7:0]  pix_hi;
  logic [XW-1:0] xs, xe, cur_x;
  logic [YW-1:0] ys, ye, cur_y;

  logic        row_end, col_end;
  logic [15:0] param_end;

  spi_byte_deserializer u_deser (
    .clk_out    (clk_out),
    .rst        (rst),
    .sck        (spi_sck),
    .mosi       (spi_mosi),
    .cs         (spi_cs),
    .dc         (spi_dc),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  function automatic logic [XW-1:0] clamp_x(input logic [15:0] v);
    return (v > 16'(WIDTH - 1)) ? XW'(WIDTH - 1) : v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [15:0] v);
    return (v > 16'(HEIGHT - 1)) ? YW'(HEIGHT - 1) : v[YW-1:0];
  endfunction

  // ">=" keeps degenerate windows (start past end) pinned to the start coordinate.
  assign col_end   = (cur_x >= xe);
  assign row_end   = (cur_y >= ye);
  assign param_end = {param_hi, byte_data};

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      state       <= ST_IDLE;
      param_idx   <= 2'd0;
      param_hi    <= 8'h00;
      param_start <= 16'h0000;
      half        <= 1'b0;
      pix_hi      <= 8'h00;
      xs          <= '0;
      ys          <= '0;
      xe          <= XW'(WIDTH - 1);
      ye          <= YW'(HEIGHT - 1);
      cur_x       <= '0;
      cur_y       <= '0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= CMD_NOP;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_done  <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (byte_valid && !byte_dc) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= byte_data;
        param_idx <= 2'd0;
        half      <= 1'b0;
        case (byte_data)
          CMD_CASET: state <= ST_CASET;
          CMD_PASET: state <= ST_PASET;
          CMD_RAMWR: begin
            state <= ST_RAMWR;
            cur_x <= xs;
            cur_y <= ys;
          end
          CMD_NOP:   state <= ST_IDLE;
          default:   state <= ST_SKIP;
        endcase
      end else if (byte_valid) begin
        case (state)
          ST_CASET, ST_PASET: begin
            param_idx <= param_idx + 2'd1;
            case (param_idx)
              2'd0:    param_hi    <= byte_data;
              2'd1:    param_start <= param_end;
              2'd2:    param_hi    <= byte_data;
              default: begin
                if (state == ST_CASET) begin
                  xs <= clamp_x(param_start);
                  xe <= clamp_x(param_end);
                end else begin
                  ys <= clamp_y(param_start);
                  ye <= clamp_y(param_end);
                end
                state <= ST_IDLE;
              end
            endcase
          end
          ST_RAMWR: begin
            if (!half) begin
              pix_hi <= byte_data;
              half   <= 1'b1;
            end else begin
              half        <= 1'b0;
              pixel_valid <= 1'b1;
              pixel_data  <= PIXEL_SIZE'({pix_hi, byte_data});
              pixel_x     <= cur_x;
              pixel_y     <= cur_y;
              if (col_end) begin
                cur_x <= xs;
                if (row_end) begin
                  cur_y      <= ys;
                  frame_done <= 1'b1;
                end else begin
                  cur_y <= cur_y + 1'b1;
                end
              end else begin
                cur_x <= cur_x + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ili9341_spi_receiver.sv
// tb/tb_ili9341_spi_receiver.sv - directed and randomized checks of the ILI9341 receiver against a window model
module tb_ili9341_spi_receiver;

  logic        clk_out = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_dc = 1'b0;
  logic        cmd_valid, pixel_valid, frame_done;
  logic [7:0]  cmd_byte;
  logic [15:0] pixel_data;
  logic [7:0]  pixel_x, pixel_y;

  ili9341_spi_receiver dut (
    .clk_out     (clk_out),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_cs      (spi_cs),
    .spi_dc      (spi_dc),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_done  (frame_done)
  );

  always #5 clk_out = ~clk_out;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] d;
    logic        fd;
  } pix_t;

  pix_t       obs_pix[$], exp_pix[$];
  logic [7:0] obs_cmd[$], exp_cmd[$];
  int checks = 0, errors = 0, stray_fd = 0;

  always @(negedge clk_out) begin
    if (pixel_valid) obs_pix.push_back('{pixel_x, pixel_y, pixel_data, frame_done});
    if (frame_done && !pixel_valid) stray_fd++;
    if (cmd_valid) obs_cmd.push_back(cmd_byte);
  end

  // Panel model: window registers, cursor, and which command the data bytes belong to.
  int m_mode, m_idx, m_half, m_hi, mxs, mxe, mys, mye, mx, my;
  int m_p[4];

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_half = 0; m_hi = 0;
    mxs = 0; mxe = 239; mys = 0; mye = 239; mx = 0; my = 0;
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] b);
    int s, e;
    if (!dc) begin
      exp_cmd.push_back(b);
      m_idx = 0;
      m_half = 0;
      if (b == 8'h2A) m_mode = 1;
      else if (b == 8'h2B) m_mode = 2;
      else if (b == 8'h2C) begin m_mode = 3; mx = mxs; my = mys; end
      else if (b == 8'h00) m_mode = 0;
      else m_mode = 4;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_p[m_idx] = b;
      m_idx++;
      if (m_idx == 4) begin
        s = m_p[0] * 256 + m_p[1];
        e = m_p[2] * 256 + m_p[3];
        if (s > 239) s = 239;
        if (e > 239) e = 239;
        if (m_mode == 1) begin mxs = s; mxe = e; end
        else begin mys = s; mye = e; end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (m_half == 0) begin
        m_hi = b;
        m_half = 1;
      end else begin
        m_half = 0;
        exp_pix.push_back('{mx[7:0], my[7:0], {m_hi[7:0], b}, (mx >= mxe && my >= mye)});
        if (mx >= mxe) begin
          mx = mxs;
          my = (my >= mye) ? mys : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(negedge clk_out);
  endtask

  task automatic shift_bits(input bit dc, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      spi_dc = dc;
      clk(2);
      spi_sck = 1'b1;
      clk(2);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send(input bit dc, input logic [7:0] b);
    shift_bits(dc, b, 8);
    clk(2);
    model_byte(dc, b);
  endtask

  task automatic send_window(input logic [7:0] op, input int s, input int e);
    send(0, op);
    send(1, 8'(s >> 8));
    send(1, 8'(s));
    send(1, 8'(e >> 8));
    send(1, 8'(e));
  endtask

  task automatic send_pixel(input logic [15:0] p);
    send(1, p[15:8]);
    send(1, p[7:0]);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    int n;
    clk(8);
    check({tag, ".npix"}, obs_pix.size(), exp_pix.size());
    n = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.pix%0d.x", tag, i), obs_pix[i].x, exp_pix[i].x);
      check($sformatf("%s.pix%0d.y", tag, i), obs_pix[i].y, exp_pix[i].y);
      check($sformatf("%s.pix%0d.data", tag, i), obs_pix[i].d, exp_pix[i].d);
      check($sformatf("%s.pix%0d.fd", tag, i), obs_pix[i].fd, exp_pix[i].fd);
    end
    check({tag, ".ncmd"}, obs_cmd.size(), exp_cmd.size());
    n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.cmd%0d", tag, i), obs_cmd[i], exp_cmd[i]);
    obs_pix.delete(); exp_pix.delete(); obs_cmd.delete(); exp_cmd.delete();
  endtask

  initial begin
    int fd_count, fd_at, xs, xe, ys, ye, npix;
    model_reset();
    clk(3);
    check("rst.cmd_valid", cmd_valid, 1'b0);
    check("rst.pixel_valid", pixel_valid, 1'b0);
    check("rst.frame_done", frame_done, 1'b0);
    check("rst.cmd_byte", cmd_byte, 8'h00);
    check("rst.pixel_data", pixel_data, 16'h0000);
    check("rst.pixel_x", pixel_x, 8'h00);
    check("rst.pixel_y", pixel_y, 8'h00);
    rst = 1'b1;
    clk(2);
    spi_cs = 1'b0;
    clk(2);

    // Default window after reset.
    send(0, 8'h2C);
    send_pixel(16'h07FF);
    send_pixel(16'hF800);
    compare_all("default");
    check("default.cmd_byte", cmd_byte, 8'h2C);

    // Small window with one wrap-around pixel.
    send_window(8'h2A, 10, 12);
    send_window(8'h2B, 20, 21);
    send(0, 8'h2C);
    for (int i = 0; i < 7; i++) send_pixel(16'($urandom));
    compare_all("window");

    // Bottom-right corner region so the frame end lands on (239,239).
    send_window(8'h2A, 232, 239);
    send_window(8'h2B, 234, 239);
    send(0, 8'h2C);
    for (int i = 0; i < 49; i++) send_pixel(16'($urandom));
    clk(8);
    fd_count = 0;
    fd_at = -1;
    foreach (obs_pix[i]) if (obs_pix[i].fd) begin fd_count++; if (fd_at < 0) fd_at = i; end
    check("corner.fd_count", fd_count, 1);
    if (fd_at >= 0) begin
      check("corner.fd_x", obs_pix[fd_at].x, 8'd239);
      check("corner.fd_y", obs_pix[fd_at].y, 8'd239);
    end
    compare_all("corner");

    // Byte aborted by CS mid-way must not disturb the pixel half.
    send(0, 8'h2C);
    send(1, 8'h12);
    shift_bits(1, 8'hFF, 5);
    clk(2);
    spi_cs = 1'b1;
    clk(4);
    spi_cs = 1'b0;
    clk(2);
    send(1, 8'hAB);
    send_pixel(16'h5A5A);
    compare_all("cs_abort");

    // Column end clamps; unknown opcode swallows its parameters.
    send_window(8'h2A, 237, 16'h0190);
    send(0, 8'hB1);
    send(1, 8'h11);
    send(1, 8'h22);
    send(1, 8'h33);
    send(0, 8'h2C);
    for (int i = 0; i < 5; i++) send_pixel(16'($urandom));
    compare_all("clamp_skip");

    // Reset between the two halves of a pixel.
    send(0, 8'h2C);
    send(1, 8'hC3);
    clk(2);
    rst = 1'b0;
    clk(1);
    rst = 1'b1;
    model_reset();
    clk(2);
    send(1, 8'h3C);
    send(0, 8'h2C);
    send_pixel(16'h1234);
    compare_all("mid_reset");

    // Randomized windows and pixel streams.
    for (int r = 0; r < 4; r++) begin
      xs = $urandom_range(0, 239);
      xe = $urandom_range(xs, (xs + 5 > 239) ? 239 : xs + 5);
      ys = $urandom_range(0, 239);
      ye = $urandom_range(ys, (ys + 4 > 239) ? 239 : ys + 4);
      npix = $urandom_range(1, 36);
      send_window(8'h2A, xs, xe);
      send_window(8'h2B, ys, ye);
      if ($urandom_range(0, 3) == 0) send(0, 8'h00);
      send(0, 8'h2C);
      for (int i = 0; i < npix; i++) send_pixel(16'($urandom));
      compare_all($sformatf("rand%0d", r));
    end

    check("stray_frame_done", stray_fd, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
